// File: rtl/mmreg_axi_arb.sv
// Round-robin arbiter that shares one AXI4-Lite master port between two
// request/done clients; each grant becomes one single-beat write or read.
module mmreg_axi_arb #(
  parameter logic [1:0] RESP_INIT = 2'b00
) (
  input  logic        mmarb_axi_aclk,
  input  logic        mmarb_axi_areset,
  input  logic        req0_valid,
  input  logic        req0_we,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [3:0]  req0_wstrb,
  input  logic        req1_valid,
  input  logic        req1_we,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [3:0]  req1_wstrb,
  output logic        req0_done,
  output logic [31:0] req0_rdata,
  output logic [1:0]  req0_resp,
  output logic        req1_done,
  output logic [31:0] req1_rdata,
  output logic [1:0]  req1_resp,
  output logic [1:0]  grant,
  output logic        busy,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  // AXI channels use strict valid/ready semantics: a beat transfers on the
  // edge where both are high, and a raised valid is held until that edge.
  typedef enum logic [2:0] {IDLE, WR_AW_W, WR_RESP, RD_AR, RD_DATA, DONE} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  grant_d;
  logic        busy_d, awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic [31:0] wdata_d, rdata0_d, rdata1_d;
  logic [3:0]  wstrb_d;
  logic        done0_d, done1_d;
  logic [1:0]  resp0_d, resp1_d;
  logic        pick1, sel_we;

  // One address register feeds both address channels; it stays put until the
  // next grant so slaves may sample it late.
  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    addr_d    = addr_q;
    grant_d   = grant;
    awvalid_d = m_axi_awvalid;
    wvalid_d  = m_axi_wvalid;
    bready_d  = m_axi_bready;
    arvalid_d = m_axi_arvalid;
    rready_d  = m_axi_rready;
    wdata_d   = m_axi_wdata;
    wstrb_d   = m_axi_wstrb;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    rdata0_d  = req0_rdata;
    rdata1_d  = req1_rdata;
    resp0_d   = req0_resp;
    resp1_d   = req1_resp;
    // last_q names the previous winner, so req1 wins only if req0 is absent
    // or req0 was served last.
    pick1  = req1_valid & (~req0_valid | ~last_q);
    sel_we = pick1 ? req1_we : req0_we;

    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          last_d  = pick1;
          grant_d = pick1 ? 2'b10 : 2'b01;
          addr_d  = pick1 ? req1_addr : req0_addr;
          wdata_d = pick1 ? req1_wdata : req0_wdata;
          wstrb_d = pick1 ? req1_wstrb : req0_wstrb;
          if (sel_we) begin
            state_d   = WR_AW_W;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_AR;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_AW_W: begin
        awvalid_d = m_axi_awvalid & ~m_axi_awready;
        wvalid_d  = m_axi_wvalid & ~m_axi_wready;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        if (m_axi_bvalid) begin
          bready_d = 1'b0;
          state_d  = DONE;
          if (grant[1]) begin
            resp1_d  = m_axi_bresp;
            rdata1_d = 32'h0;
            done1_d  = 1'b1;
          end else begin
            resp0_d  = m_axi_bresp;
            rdata0_d = 32'h0;
            done0_d  = 1'b1;
          end
        end
      end
      RD_AR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (m_axi_rvalid) begin
          rready_d = 1'b0;
          state_d  = DONE;
          if (grant[1]) begin
            resp1_d  = m_axi_rresp;
            rdata1_d = m_axi_rdata;
            done1_d  = 1'b1;
          end else begin
            resp0_d  = m_axi_rresp;
            rdata0_d = m_axi_rdata;
            done0_d  = 1'b1;
          end
        end
      end
      DONE: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge mmarb_axi_aclk or posedge mmarb_axi_areset) begin
    if (mmarb_axi_areset) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      addr_q        <= 32'h0;
      grant         <= 2'b00;
      busy          <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      m_axi_wdata   <= 32'h0;
      m_axi_wstrb   <= 4'h0;
      req0_done     <= 1'b0;
      req1_done     <= 1'b0;
      req0_rdata    <= 32'h0;
      req1_rdata    <= 32'h0;
      req0_resp     <= RESP_INIT;
      req1_resp     <= RESP_INIT;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      addr_q        <= addr_d;
      grant         <= grant_d;
      busy          <= busy_d;
      m_axi_awvalid <= awvalid_d;
      m_axi_wvalid  <= wvalid_d;
      m_axi_bready  <= bready_d;
      m_axi_arvalid <= arvalid_d;
      m_axi_rready  <= rready_d;
      m_axi_wdata   <= wdata_d;
      m_axi_wstrb   <= wstrb_d;
      req0_done     <= done0_d;
      req1_done     <= done1_d;
      req0_rdata    <= rdata0_d;
      req1_rdata    <= rdata1_d;
      req0_resp     <= resp0_d;
      req1_resp     <= resp1_d;
    end
  end

endmodule

// File: tb/tb_mmreg_axi_arb.sv
// Bench for mmreg_axi_arb: behavioural register slave at 0x100, table-driven
// single requests, plus contention, backpressure, error and reset sequences.
module tb_mmreg_axi_arb;

  localparam logic [1:0] RINIT = 2'b01;
  localparam logic [31:0] TARG = 32'h100;

  logic clk, rst;
  logic req0_valid, req0_we, req1_valid, req1_we;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic [3:0]  req0_wstrb, req1_wstrb;
  logic req0_done, req1_done, busy;
  logic [31:0] req0_rdata, req1_rdata;
  logic [1:0]  req0_resp, req1_resp, grant;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic m_axi_rvalid, m_axi_rready;

  mmreg_axi_arb #(.RESP_INIT(RINIT)) dut (
    .mmarb_axi_aclk(clk), .mmarb_axi_areset(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb),
    .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_resp(req0_resp),
    .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_resp(req1_resp),
    .grant(grant), .busy(busy),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- slave model ----------------
  int aw_delay = 0;
  logic b_force = 1'b0;
  logic r_hold = 1'b0;
  logic [31:0] slv_reg;

  initial begin
    int aw_cnt;
    aw_cnt = 0;
    slv_reg = 32'h0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    forever begin
      @(negedge clk);
      if (m_axi_awvalid) begin
        m_axi_awready = (aw_cnt >= aw_delay);
        aw_cnt++;
      end else begin
        m_axi_awready = 1'b0;
        aw_cnt = 0;
      end
      m_axi_wready  = m_axi_wvalid;
      m_axi_arready = m_axi_arvalid;
      m_axi_bvalid  = m_axi_bready;
      if (m_axi_bready) begin
        if (b_force) m_axi_bresp = 2'b10;
        else if (m_axi_awaddr == TARG) begin
          m_axi_bresp = 2'b00;
          for (int b = 0; b < 4; b++)
            if (m_axi_wstrb[b]) slv_reg[8*b +: 8] = m_axi_wdata[8*b +: 8];
        end else m_axi_bresp = 2'b11;
      end
      m_axi_rvalid = m_axi_rready && !r_hold;
      m_axi_rdata  = (m_axi_araddr == TARG) ? slv_reg : 32'hDEADBEEF;
      m_axi_rresp  = (m_axi_araddr == TARG) ? 2'b00 : 2'b11;
    end
  end

  // ---------------- scoreboard ----------------
  // entry = {owner one-hot, rdata, resp}
  logic [35:0] exp_q[$];
  logic [31:0] sh_rdata[2];
  logic [1:0]  sh_resp[2];

  task automatic reset_shadow();
    sh_rdata[0] = 32'h0; sh_rdata[1] = 32'h0;
    sh_resp[0] = RINIT;  sh_resp[1] = RINIT;
  endtask

  initial begin
    logic [35:0] e;
    int o;
    forever begin
      @(negedge clk);
      if (req0_done || req1_done) begin
        if (exp_q.size() == 0) chk("spurious_done", {req1_done, req0_done}, 2'b00);
        else begin
          e = exp_q.pop_front();
          o = e[35] ? 1 : 0;
          sh_rdata[o] = e[33:2];
          sh_resp[o]  = e[1:0];
          chk("done_owner", {req1_done, req0_done}, e[35:34]);
          chk("grant_at_done", grant, e[35:34]);
          chk("rdata0", req0_rdata, sh_rdata[0]);
          chk("rdata1", req1_rdata, sh_rdata[1]);
          chk("resp0", req0_resp, sh_resp[0]);
          chk("resp1", req1_resp, sh_resp[1]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  int aw_cyc, w_cyc, bready_at, addr_bad;

  task automatic do_req(input int who, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input logic [31:0] e_rdata, input logic [1:0] e_resp,
                        output int lat);
    @(negedge clk);
    exp_q.push_back({(who == 1) ? 2'b10 : 2'b01, e_rdata, e_resp});
    if (who == 1) begin
      req1_valid = 1; req1_we = we; req1_addr = addr; req1_wdata = wdata; req1_wstrb = wstrb;
    end else begin
      req0_valid = 1; req0_we = we; req0_addr = addr; req0_wdata = wdata; req0_wstrb = wstrb;
    end
    lat = 0; aw_cyc = 0; w_cyc = 0; bready_at = 0; addr_bad = 0;
    do begin
      @(negedge clk);
      lat++;
      if (m_axi_awvalid) aw_cyc++;
      if (m_axi_wvalid) w_cyc++;
      if (m_axi_bready && bready_at == 0) bready_at = lat;
      if (busy && m_axi_awaddr !== addr) addr_bad++;
    end while (!(req0_done || req1_done) && lat < 40);
    if (lat >= 40) chk("req_timeout", {req1_done, req0_done}, (who == 1) ? 2'b10 : 2'b01);
    req0_valid = 0;
    req1_valid = 0;
  endtask

  typedef struct {
    int who; logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;
    logic [31:0] e_rdata; logic [1:0] e_resp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat;
    int dn, t;
    int done_at[4];
    logic [1:0] gseq[4];

    vecs[0] = '{0, 1'b1, 32'h100, 32'h000000A5, 4'hF, 32'h0,        2'b00};
    vecs[1] = '{0, 1'b0, 32'h100, 32'h0,        4'h0, 32'h000000A5, 2'b00};
    vecs[2] = '{1, 1'b1, 32'h100, 32'h12345678, 4'h3, 32'h0,        2'b00};
    vecs[3] = '{1, 1'b0, 32'h100, 32'h0,        4'h0, 32'h00005678, 2'b00};
    vecs[4] = '{0, 1'b0, 32'h200, 32'h0,        4'h0, 32'hDEADBEEF, 2'b11};
    vecs[5] = '{1, 1'b1, 32'h204, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b11};
    vecs[6] = '{0, 1'b0, 32'h100, 32'h0,        4'h0, 32'h00005678, 2'b00};
    vecs[7] = '{0, 1'b1, 32'h100, 32'hCAFE0000, 4'hC, 32'h0,        2'b00};
    vecs[8] = '{1, 1'b0, 32'h100, 32'h0,        4'h0, 32'hCAFE5678, 2'b00};

    rst = 1'b1;
    req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0; req0_wstrb = 0;
    req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0; req1_wstrb = 0;
    reset_shadow();
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 5'b0);
    chk("rst_addr", {m_axi_awaddr, m_axi_araddr}, 64'h0);
    chk("rst_wdata", {m_axi_wstrb, m_axi_wdata}, 36'h0);
    chk("rst_rdata", {req0_rdata, req1_rdata}, 64'h0);
    chk("rst_resp", {req0_resp, req1_resp}, {RINIT, RINIT});
    chk("rst_done", {req0_done, req1_done}, 2'b00);
    rst = 1'b0;
    @(negedge clk);

    // Contention: both held, grants must alternate starting with req0.
    gseq = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int k = 0; k < 4; k++) exp_q.push_back({gseq[k], 32'h0, 2'b00});
    req0_valid = 1; req0_we = 0; req0_addr = TARG;
    req1_valid = 1; req1_we = 0; req1_addr = TARG;
    dn = 0; t = 0;
    while (dn < 4 && t < 60) begin
      @(negedge clk);
      t++;
      if (req0_done || req1_done) begin
        chk("rr_grant", grant, gseq[dn]);
        done_at[dn] = t;
        dn++;
      end
    end
    req0_valid = 0; req1_valid = 0;
    chk("rr_done_count", dn, 4);
    for (int k = 0; k < dn; k++) chk("rr_done_cycle", done_at[k], 3 + 4 * k);

    // Table of single zero-wait requests.
    for (int i = 0; i < 9; i++) begin
      do_req(vecs[i].who, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb,
             vecs[i].e_rdata, vecs[i].e_resp, lat);
      chk("vec_latency", lat, 3);
    end

    // Write backpressure: awready three cycles late, wready immediate.
    aw_delay = 3;
    do_req(0, 1'b1, TARG, 32'h0000005A, 4'h1, 32'h0, 2'b00, lat);
    aw_delay = 0;
    chk("bp_latency", lat, 6);
    chk("bp_aw_cycles", aw_cyc, 4);
    chk("bp_w_cycles", w_cyc, 1);
    chk("bp_bready_cycle", bready_at, 5);
    chk("bp_addr_stable", addr_bad, 0);
    chk("bp_slave_reg", slv_reg, 32'hCAFE565A);

    // Error response on a req1 write; req0 outputs are checked against shadow.
    b_force = 1'b1;
    do_req(1, 1'b1, TARG, 32'h0BAD0BAD, 4'hF, 32'h0, 2'b10, lat);
    b_force = 1'b0;
    chk("err_latency", lat, 3);
    chk("err_resp1", req1_resp, 2'b10);
    chk("err_slave_reg", slv_reg, 32'hCAFE565A);

    // Reset while stalled in the read data phase.
    @(negedge clk);
    r_hold = 1'b1;
    req0_valid = 1; req0_we = 0; req0_addr = TARG;
    repeat (2) @(negedge clk);
    chk("mid_rready", m_axi_rready, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rready", m_axi_rready, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_grant", grant, 2'b00);
    chk("mid_rst_done", {req0_done, req1_done}, 2'b00);
    reset_shadow();
    @(negedge clk);
    req0_valid = 0;
    r_hold = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_req(1, 1'b0, TARG, 32'h0, 4'h0, 32'hCAFE565A, 2'b00, lat);
    chk("post_rst_latency", lat, 3);
    chk("post_rst_resp0", req0_resp, RINIT);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
